// File: rtl/ula_seq.sv
// Sequencer feeding a combinational ULA: registers one request, holds it for one
// execute cycle, then captures result, zero flag and accumulator for a valid/ready consumer.
module ula_seq #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] srcA,
  output logic [WIDTH-1:0] srcB,
  output logic [3:0]       ula_control,
  input  logic [WIDTH-1:0] ula_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] srcA_q, srcA_d;
  logic [WIDTH-1:0] srcB_q, srcB_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             accept;

  // Opcodes 100 and 101 have no ULA function.
  function automatic logic op_legal(input logic [2:0] op);
    return !(op[2] && !op[1]);
  endfunction

  assign in_ready    = (state_q == IDLE) && rst_n;
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid && in_ready;
  assign srcA        = srcA_q;
  assign srcB        = srcB_q;
  assign ula_control = ctrl_q;
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_illegal = ill_q;
  assign acc         = acc_q;

  always_comb begin
    state_d = state_q;
    srcA_d  = srcA_q;
    srcB_d  = srcB_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          srcA_d = in_acc ? acc_q : in_a;
          srcB_d = in_b;
          ctrl_d = {1'b0, in_op};
          if (op_legal(in_op)) begin
            state_d = EXEC;
          end else begin
            // Illegal requests skip EXEC and report a zero result directly.
            state_d = DONE;
            ill_d   = 1'b1;
            res_d   = '0;
            zero_d  = 1'b1;
          end
        end
      end
      EXEC: begin
        res_d   = ula_result;
        zero_d  = (ula_result == '0);
        ill_d   = 1'b0;
        acc_d   = ula_result;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      srcA_q  <= '0;
      srcB_q  <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      srcA_q  <= srcA_d;
      srcB_q  <= srcB_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: a behavioural ULA closes the loop, and a reference model
// tracks the accumulator and expected results for directed and random requests.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic       in_acc;
  logic [8:0] in_a, in_b;
  logic [8:0] srcA, srcB;
  logic [3:0] ula_control;
  logic [8:0] ula_result;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_result;
  logic       out_zero;
  logic       out_illegal;
  logic [8:0] acc;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] m_acc = '0;

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_acc(in_acc), .in_a(in_a), .in_b(in_b),
    .srcA(srcA), .srcB(srcB), .ula_control(ula_control), .ula_result(ula_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .acc(acc)
  );

  // Plain-arithmetic ULA; illegal codes give a recognisable junk value.
  function automatic logic [8:0] ula_ref(input logic [3:0] ctl, input logic [8:0] a, input logic [8:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (ctl)
      4'd0:    r = ia & ib;
      4'd1:    r = ia | ib;
      4'd2:    r = (ia + ib) % 512;
      4'd3:    r = 511 - (ia | ib);
      4'd6:    r = (ia - ib + 512) % 512;
      4'd7:    r = (ia < ib) ? 1 : 0;
      default: r = 32'h1A5;
    endcase
    return r[8:0];
  endfunction

  always_comb ula_result = ula_ref(ula_control, srcA, srcB);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic use_acc,
                        input logic [8:0] a, input logic [8:0] b, input int bp);
    logic [8:0] ea, er;
    logic       legal;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_acc = use_acc; in_a = a; in_b = b; out_ready = 1'b0;
    ea    = use_acc ? m_acc : a;
    legal = (op != 3'd4) && (op != 3'd5);
    @(negedge clk);
    in_valid = 1'b0; in_a = 9'($urandom); in_b = 9'($urandom);
    chk("srcA", srcA, ea);
    chk("srcB", srcB, b);
    chk("ctl", ula_control, {1'b0, op});
    chk("busy_ready", in_ready, 0);
    if (legal) begin
      chk("exec_valid", out_valid, 0);
      er = ula_ref({1'b0, op}, ea, b);
      @(negedge clk);
    end else begin
      er = '0;
    end
    chk("valid", out_valid, 1);
    chk("result", out_result, er);
    chk("illegal", out_illegal, !legal);
    if (legal) begin
      chk("zero", out_zero, er == 9'd0);
      m_acc = er;
    end
    chk("acc", acc, m_acc);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, er);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_valid", out_valid, 0);
    chk("hs_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_acc = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_srcA", srcA, 0);
    chk("rst_ctl", ula_control, 0);
    chk("rst_result", out_result, 0);
    chk("rst_acc", acc, 0);
    rst_n = 1'b1;

    // Directed cases
    run_op(3'b010, 1'b0, 9'h1FF, 9'h001, 0);
    chk("add_ovf_zero", out_zero, 1);
    run_op(3'b110, 1'b0, 9'd5, 9'd7, 0);
    chk("sub_wrap", out_result, 9'h1FE);
    run_op(3'b010, 1'b1, 9'h0AA, 9'd3, 0);
    chk("acc_chain", out_result, 9'h001);
    run_op(3'b111, 1'b0, 9'd3, 9'd200, 0);
    run_op(3'b111, 1'b0, 9'd200, 9'd3, 0);
    run_op(3'b011, 1'b0, 9'h0F0, 9'h00F, 0);
    chk("nor", out_result, 9'h100);
    run_op(3'b000, 1'b0, 9'h1F0, 9'h0FF, 1);
    chk("and", out_result, 9'h0F0);
    run_op(3'b001, 1'b0, 9'h055, 9'h000, 0);
    run_op(3'b100, 1'b0, 9'h123, 9'h045, 2);
    chk("ill_acc", acc, 9'h055);
    run_op(3'b101, 1'b1, 9'h000, 9'h011, 0);

    // Backpressure with a new request held by the producer
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b010; in_acc = 1'b0; in_a = 9'h010; in_b = 9'h020;
    @(negedge clk);
    in_op = 3'b001; in_a = 9'h101; in_b = 9'h0A0;
    @(negedge clk);
    chk("bp2_valid", out_valid, 1);
    chk("bp2_result", out_result, 9'h030);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp2_hold", out_result, 9'h030);
      chk("bp2_ready", in_ready, 0);
      chk("bp2_srcB", srcB, 9'h020);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp2_idle", out_valid, 0);
    chk("bp2_notyet", srcB, 9'h020);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp2_accA", srcA, 9'h101);
    chk("bp2_accB", srcB, 9'h0A0);
    @(negedge clk);
    chk("bp2_res2", out_result, 9'h1A1);
    m_acc = 9'h1A1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp2_done", out_valid, 0);

    // Random requests
    for (int n = 0; n < 80; n++) begin
      logic [8:0] ra, rb;
      ra = 9'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? ra : 9'($urandom);
      run_op(3'($urandom_range(0, 7)), 1'($urandom), ra, rb, $urandom_range(0, 3));
    end

    // Reset at the EXEC-ending edge
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b010; in_acc = 1'b0; in_a = 9'd1; in_b = 9'd2;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_valid", out_valid, 0);
    chk("mid_ready", in_ready, 0);
    chk("mid_srcA", srcA, 0);
    chk("mid_srcB", srcB, 0);
    chk("mid_ctl", ula_control, 0);
    chk("mid_result", out_result, 0);
    chk("mid_zero", out_zero, 0);
    chk("mid_acc", acc, 0);
    @(negedge clk);
    chk("mid_ready2", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_valid", out_valid, 0);
    end
    m_acc = '0;
    run_op(3'b010, 1'b1, 9'h0FF, 9'h004, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
